trap_ctrl: RTL

Trap initiator for the Mini-RISC-V core. It arbitrates ecall and UART interrupt requests and drains the pipeline. It then issues a one-cycle trap request to the CSR file with the exception PC and cause, and redirects fetch to mtvec. On mret it redirects fetch to mepc and re-arms for the next trap.

---
 rtl/trap_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap initiator for the Mini-RISC-V core.
// Arbitrates ecall / timer / UART requests, drains the pipeline for
// FLUSH_CYCLES, pulses trigger_trap to the CSR file and redirects fetch to
// mtvec. On mret it redirects to mepc and re-arms for the next trap.
// Optional build macro: TRAP_CTRL_TIMER_IRQ_EN adds a free-running timer
// interrupt source of period TIMER_PERIOD (absent when undefined).
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2,     // 1..15
  parameter int TIMER_PERIOD = 1000   // only used with TRAP_CTRL_TIMER_IRQ_EN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall,
  input  logic        uart_irq,
  input  logic        irq_en,
  input  logic        mret,
  input  logic        pc_valid,
  input  logic [31:0] pres_addr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        trigger_trap,
  output logic [31:0] trap_epc,
  output logic [31:0] mcause,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trapping
);

  localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_UART  = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP,
    S_HANDLER,
    S_RETURN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ecall_pend_q, ecall_pend_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        ecall_req;
  logic        timer_req;
  logic        uart_req;
  logic        any_req;
  logic        accept;
  logic        ecall_take;
  logic [31:0] cause;

  // Request arbitration: ecall > timer > UART. UART is a live level only.
  assign ecall_req  = ecall_pend_q | ecall;
  assign uart_req   = irq_en & uart_irq;
  assign any_req    = ecall_req | timer_req | uart_req;
  assign accept     = (state_q == S_IDLE) & pc_valid & any_req;
  assign ecall_take = accept & ecall_req;
  assign cause      = ecall_req ? CAUSE_ECALL :
                      timer_req ? CAUSE_TIMER : CAUSE_UART;

`ifdef TRAP_CTRL_TIMER_IRQ_EN
  localparam int TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;

  logic [TW-1:0] tmr_q, tmr_d;
  logic          timer_pend_q, timer_pend_d;
  logic          tmr_wrap;
  logic          timer_take;

  assign tmr_wrap   = (tmr_q == TW'(TIMER_PERIOD - 1));
  assign timer_take = accept & ~ecall_req & timer_req;
  assign timer_req  = irq_en & timer_pend_q;

  // Timer next state: wrap sets the pending flag; a fresh wrap beats a clear.
  always_comb begin
    tmr_d        = tmr_wrap ? '0 : tmr_q + 1'b1;
    timer_pend_d = tmr_wrap | (timer_pend_q & ~timer_take);
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q        <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      tmr_q        <= tmr_d;
      timer_pend_q <= timer_pend_d;
    end
  end
`else
  logic unused_timer_period;

  assign timer_req           = 1'b0;
  assign unused_timer_period = ^TIMER_PERIOD;
`endif

  // Next-state and output decode for the trap sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    trap_epc_d   = trap_epc_q;
    mcause_d     = mcause_q;
    ecall_pend_d = (ecall_pend_q | ecall) & ~ecall_take;
    flush        = 1'b0;
    trigger_trap = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    trapping     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          trap_epc_d = pres_addr;
          mcause_d   = cause;
          cnt_d      = 4'(FLUSH_CYCLES - 1);
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TRAP: begin
        trigger_trap = 1'b1;
        flush        = 1'b1;
        trapping     = 1'b1;
        redirect     = 1'b1;
        redirect_pc  = mtvec;
        state_d      = S_HANDLER;
      end
      S_HANDLER: begin
        trapping = 1'b1;
        if (mret) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        redirect    = 1'b1;
        redirect_pc = mepc;
        flush       = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, drain counter, pending ecall and captured trap info.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      ecall_pend_q <= 1'b0;
      trap_epc_q   <= '0;
      mcause_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ecall_pend_q <= ecall_pend_d;
      trap_epc_q   <= trap_epc_d;
      mcause_q     <= mcause_d;
    end
  end

  assign trap_epc = trap_epc_q;
  assign mcause   = mcause_q;

endmodule
